mc_cu: RTL and testbench

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_cu.sv | 223 ++++++++++++++++++++++
 tb/tb_mc_cu.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit: a six-state FSM (IF/ID/EXE/MEM/WB/HALT)
// with an optional memory handshake, a bounded wait counter, and sticky
// trap flags for undecoded instructions and memory timeouts.
module mc_cu #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int WAIT_MAX      = 15,
    parameter int TRAP_ILLEGAL  = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       iord,
    output logic       wmem,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       sext,
    output logic       shift,
    output logic [1:0] alusrcb,
    output logic       alusrca,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state,
    output logic       illegal,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // The counter value seen in the last permitted waiting cycle.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);
    localparam bit         USE_HS    = (MEM_HANDSHAKE != 0);
    localparam bit         TRAP      = (TRAP_ILLEGAL != 0);

    state_t     cur;
    logic [3:0] wait_cnt;

    logic r_type;
    logic is_add, is_sub, is_and, is_or, is_xor, is_sll, is_srl, is_sra, is_jr;
    logic is_addi, is_andi, is_ori, is_xori, is_lw, is_sw, is_beq, is_bne;
    logic is_lui, is_j, is_jal;
    logic imm_alu, is_shift, decoded, mem_done, timeout;
    logic [3:0] aluc_dec;

    assign r_type  = (op == 6'b000000);
    assign is_add  = r_type && (func == 6'b100000);
    assign is_sub  = r_type && (func == 6'b100010);
    assign is_and  = r_type && (func == 6'b100100);
    assign is_or   = r_type && (func == 6'b100101);
    assign is_xor  = r_type && (func == 6'b100110);
    assign is_sll  = r_type && (func == 6'b000000);
    assign is_srl  = r_type && (func == 6'b000010);
    assign is_sra  = r_type && (func == 6'b000011);
    assign is_jr   = r_type && (func == 6'b001000);
    assign is_addi = (op == 6'b001000);
    assign is_andi = (op == 6'b001100);
    assign is_ori  = (op == 6'b001101);
    assign is_xori = (op == 6'b001110);
    assign is_lui  = (op == 6'b001111);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_bne  = (op == 6'b000101);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);

    assign imm_alu  = is_addi | is_andi | is_ori | is_xori | is_lui;
    assign is_shift = is_sll | is_srl | is_sra;
    assign decoded  = is_add | is_sub | is_and | is_or | is_xor | is_shift | is_jr
                    | imm_alu | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;

    // Without a handshake every memory cycle completes immediately.
    assign mem_done = !USE_HS || mem_ready;
    assign timeout  = !mem_done && (wait_cnt == WAIT_LAST);
    assign state    = cur;

    // ALU operation implied by the current instruction.
    always_comb begin
        aluc_dec = 4'b0000;
        if (is_sub || is_beq || is_bne) aluc_dec = 4'b0100;
        else if (is_and || is_andi)     aluc_dec = 4'b0001;
        else if (is_or || is_ori)       aluc_dec = 4'b0101;
        else if (is_xor || is_xori)     aluc_dec = 4'b0010;
        else if (is_lui)                aluc_dec = 4'b0110;
        else if (is_sll)                aluc_dec = 4'b0011;
        else if (is_srl)                aluc_dec = 4'b0111;
        else if (is_sra)                aluc_dec = 4'b1111;
    end

    // State sequencing, wait counting and the sticky trap flags.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cur      <= S_IF;
            wait_cnt <= 4'd0;
            illegal  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            wait_cnt <= 4'd0;
            case (cur)
                S_IF: begin
                    if (mem_done) begin
                        cur <= S_ID;
                    end else if (timeout) begin
                        cur     <= S_HALT;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ID: begin
                    if (is_j || is_jal || is_jr) begin
                        cur <= S_IF;
                    end else if (!decoded) begin
                        if (TRAP) begin
                            cur     <= S_HALT;
                            illegal <= 1'b1;
                        end else begin
                            cur <= S_IF;
                        end
                    end else begin
                        cur <= S_EXE;
                    end
                end
                S_EXE: begin
                    if (is_beq || is_bne)    cur <= S_IF;
                    else if (is_lw || is_sw) cur <= S_MEM;
                    else                     cur <= S_WB;
                end
                S_MEM: begin
                    if (mem_done) begin
                        cur <= is_lw ? S_WB : S_IF;
                    end else if (timeout) begin
                        cur     <= S_HALT;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_WB:    cur <= S_IF;
                S_HALT:  cur <= S_HALT;
                default: cur <= S_IF;
            endcase
        end
    end

    // Control outputs decoded from the registered state and live inputs.
    always_comb begin
        wpc      = 1'b0;
        wir      = 1'b0;
        iord     = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        shift    = 1'b0;
        alusrcb  = 2'b00;
        alusrca  = 1'b0;
        aluc     = 4'b0000;
        pcsource = 2'b00;
        case (cur)
            S_IF: begin
                alusrcb = 2'b01;
                wpc     = mem_done;
                wir     = mem_done;
            end
            S_ID: begin
                alusrcb = 2'b11;
                if (is_j || is_jal) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                end
                if (is_jal) begin
                    wreg = 1'b1;
                    jal  = 1'b1;
                end
                if (is_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                shift   = is_shift;
                alusrcb = (imm_alu || is_lw || is_sw) ? 2'b10 : 2'b00;
                sext    = is_addi | is_lw | is_sw | is_beq | is_bne;
                aluc    = aluc_dec;
                if (is_beq || is_bne) begin
                    wpc      = (is_beq && z) || (is_bne && !z);
                    pcsource = 2'b01;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                wmem = is_sw;
                aluc = aluc_dec;
            end
            S_WB: begin
                wreg  = 1'b1;
                m2reg = is_lw;
                regrt = imm_alu | is_lw;
                aluc  = aluc_dec;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mc_cu.sv
// Directed testbench for mc_cu. Three instances share the stimulus:
// d0 uses default parameters, d1 retires illegal opcodes as NOPs and
// d2 times out after four memory wait cycles.
module tb_mc_cu;

    logic       clock = 1'b0;
    logic       resetn;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       mem_ready;

    logic       wpc_v      [3];
    logic       wir_v      [3];
    logic       iord_v     [3];
    logic       wmem_v     [3];
    logic       wreg_v     [3];
    logic       regrt_v    [3];
    logic       m2reg_v    [3];
    logic       jal_v      [3];
    logic       sext_v     [3];
    logic       shift_v    [3];
    logic [1:0] alusrcb_v  [3];
    logic       alusrca_v  [3];
    logic [3:0] aluc_v     [3];
    logic [1:0] pcsource_v [3];
    logic [2:0] state_v    [3];
    logic       illegal_v  [3];
    logic       mem_err_v  [3];

    typedef enum int {
        F_STATE, F_WPC, F_WIR, F_IORD, F_WMEM, F_WREG, F_REGRT, F_M2REG, F_JAL,
        F_SEXT, F_SHIFT, F_ALUSRCB, F_ALUSRCA, F_ALUC, F_PCSRC, F_ILL, F_MERR
    } fld_t;

    typedef struct {
        string      tag;
        int         d;
        fld_t       f;
        logic [3:0] val;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic [3:0] aluc;
        bit         imm;
        bit         shf;
        bit         sx;
    } alu_case_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    alu_case_t alu_tbl [13] = '{
        '{6'b000000, 6'b100000, 4'b0000, 1'b0, 1'b0, 1'b0},
        '{6'b000000, 6'b100010, 4'b0100, 1'b0, 1'b0, 1'b0},
        '{6'b000000, 6'b100100, 4'b0001, 1'b0, 1'b0, 1'b0},
        '{6'b000000, 6'b100101, 4'b0101, 1'b0, 1'b0, 1'b0},
        '{6'b000000, 6'b100110, 4'b0010, 1'b0, 1'b0, 1'b0},
        '{6'b000000, 6'b000000, 4'b0011, 1'b0, 1'b1, 1'b0},
        '{6'b000000, 6'b000010, 4'b0111, 1'b0, 1'b1, 1'b0},
        '{6'b000000, 6'b000011, 4'b1111, 1'b0, 1'b1, 1'b0},
        '{6'b001000, 6'b000000, 4'b0000, 1'b1, 1'b0, 1'b1},
        '{6'b001100, 6'b000000, 4'b0001, 1'b1, 1'b0, 1'b0},
        '{6'b001101, 6'b000000, 4'b0101, 1'b1, 1'b0, 1'b0},
        '{6'b001110, 6'b000000, 4'b0010, 1'b1, 1'b0, 1'b0},
        '{6'b001111, 6'b000000, 4'b0110, 1'b1, 1'b0, 1'b0}
    };

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            mc_cu #(
                .MEM_HANDSHAKE(1),
                .WAIT_MAX     ((g == 2) ? 4 : 15),
                .TRAP_ILLEGAL ((g == 1) ? 0 : 1)
            ) dut (
                .clock    (clock),
                .resetn   (resetn),
                .op       (op),
                .func     (func),
                .z        (z),
                .mem_ready(mem_ready),
                .wpc      (wpc_v[g]),
                .wir      (wir_v[g]),
                .iord     (iord_v[g]),
                .wmem     (wmem_v[g]),
                .wreg     (wreg_v[g]),
                .regrt    (regrt_v[g]),
                .m2reg    (m2reg_v[g]),
                .jal      (jal_v[g]),
                .sext     (sext_v[g]),
                .shift    (shift_v[g]),
                .alusrcb  (alusrcb_v[g]),
                .alusrca  (alusrca_v[g]),
                .aluc     (aluc_v[g]),
                .pcsource (pcsource_v[g]),
                .state    (state_v[g]),
                .illegal  (illegal_v[g]),
                .mem_err  (mem_err_v[g])
            );
        end
    endgenerate

    // Picks one output of one instance, zero-extended to four bits.
    function automatic logic [3:0] observe(int d, fld_t f);
        case (f)
            F_STATE:   return {1'b0, state_v[d]};
            F_WPC:     return {3'b0, wpc_v[d]};
            F_WIR:     return {3'b0, wir_v[d]};
            F_IORD:    return {3'b0, iord_v[d]};
            F_WMEM:    return {3'b0, wmem_v[d]};
            F_WREG:    return {3'b0, wreg_v[d]};
            F_REGRT:   return {3'b0, regrt_v[d]};
            F_M2REG:   return {3'b0, m2reg_v[d]};
            F_JAL:     return {3'b0, jal_v[d]};
            F_SEXT:    return {3'b0, sext_v[d]};
            F_SHIFT:   return {3'b0, shift_v[d]};
            F_ALUSRCB: return {2'b0, alusrcb_v[d]};
            F_ALUSRCA: return {3'b0, alusrca_v[d]};
            F_ALUC:    return aluc_v[d];
            F_PCSRC:   return {2'b0, pcsource_v[d]};
            F_ILL:     return {3'b0, illegal_v[d]};
            F_MERR:    return {3'b0, mem_err_v[d]};
            default:   return 4'b0000;
        endcase
    endfunction

    // Drives the instruction fields and handshake for the coming cycle.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] fn,
                                 input logic zz, input logic rdy);
        op        = o;
        func      = fn;
        z         = zz;
        mem_ready = rdy;
    endtask

    // Queues an expected output value for the current cycle.
    task automatic exd(input string tag, input int d, input fld_t f, input int v);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.f   = f;
        e.val = 4'(v);
        sbq.push_back(e);
    endtask

    task automatic ex(input string tag, input fld_t f, input int v);
        exd(tag, 0, f, v);
    endtask

    // Lets outputs settle, then drains the queue against the instances.
    task automatic checkOutput();
        exp_t       e;
        logic [3:0] obs;
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.d, e.f);
            tests++;
            assert (obs === e.val) else begin
                fails++;
                $error("[TB] FAIL %s d%0d %s: observed %0h expected %0h",
                       e.tag, e.d, e.f.name(), obs, e.val);
            end
        end
    endtask

    // Advances one cycle, leaving the bench at the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    // Directed sequence covering each instruction class and the traps.
    initial begin
        resetn = 1'b0;
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
        @(negedge clock);
        do_reset();
        for (int d = 0; d < 3; d++) begin
            exd("reset", d, F_STATE, 0);
            exd("reset", d, F_ILL, 0);
            exd("reset", d, F_MERR, 0);
        end
        checkOutput();

        // add with memory always ready
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
        ex("add IF", F_STATE, 0); ex("add IF", F_WPC, 1); ex("add IF", F_WIR, 1);
        ex("add IF", F_IORD, 0); ex("add IF", F_ALUSRCB, 1); ex("add IF", F_WREG, 0);
        checkOutput(); step();
        ex("add ID", F_STATE, 1); ex("add ID", F_ALUSRCB, 3); ex("add ID", F_WPC, 0);
        ex("add ID", F_WREG, 0);
        checkOutput(); step();
        ex("add EXE", F_STATE, 2); ex("add EXE", F_ALUC, 0); ex("add EXE", F_ALUSRCA, 1);
        ex("add EXE", F_WREG, 0);
        checkOutput(); step();
        ex("add WB", F_STATE, 4); ex("add WB", F_WREG, 1); ex("add WB", F_REGRT, 0);
        checkOutput(); step();
        ex("add IF2", F_STATE, 0); ex("add IF2", F_WREG, 0);
        checkOutput();

        // ALU instructions: EXE decode and WB register select
        for (int i = 0; i < 13; i++) begin
            string t;
            t = $sformatf("alu op=%02h fn=%02h", alu_tbl[i].op, alu_tbl[i].func);
            applyStimulus(alu_tbl[i].op, alu_tbl[i].func, 1'b0, 1'b1);
            ex(t, F_STATE, 0);
            checkOutput(); step();
            ex(t, F_STATE, 1);
            checkOutput(); step();
            ex(t, F_STATE, 2); ex(t, F_ALUC, int'(alu_tbl[i].aluc));
            ex(t, F_SHIFT, int'(alu_tbl[i].shf)); ex(t, F_SEXT, int'(alu_tbl[i].sx));
            ex(t, F_ALUSRCB, alu_tbl[i].imm ? 2 : 0); ex(t, F_ALUSRCA, 1);
            checkOutput(); step();
            ex(t, F_STATE, 4); ex(t, F_WREG, 1); ex(t, F_REGRT, int'(alu_tbl[i].imm));
            ex(t, F_M2REG, 0);
            checkOutput(); step();
        end

        // lw with three not-ready cycles in MEM
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b1);
        ex("lw IF", F_STATE, 0); checkOutput(); step();
        ex("lw ID", F_STATE, 1); checkOutput(); step();
        ex("lw EXE", F_STATE, 2); ex("lw EXE", F_ALUSRCB, 2); ex("lw EXE", F_SEXT, 1);
        ex("lw EXE", F_ALUC, 0);
        checkOutput(); step();
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ex("lw MEM wait", F_STATE, 3); ex("lw MEM wait", F_IORD, 1);
            ex("lw MEM wait", F_WMEM, 0);
            checkOutput(); step();
        end
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b1);
        ex("lw MEM rdy", F_STATE, 3); ex("lw MEM rdy", F_IORD, 1);
        checkOutput(); step();
        ex("lw WB", F_STATE, 4); ex("lw WB", F_M2REG, 1); ex("lw WB", F_REGRT, 1);
        ex("lw WB", F_WREG, 1); ex("lw WB", F_IORD, 0);
        checkOutput(); step();
        ex("lw done", F_STATE, 0); checkOutput();

        // sw completing, then a second sw cut off by reset mid-MEM
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b1);
        ex("sw IF", F_STATE, 0); checkOutput(); step();
        ex("sw ID", F_STATE, 1); checkOutput(); step();
        ex("sw EXE", F_STATE, 2); ex("sw EXE", F_ALUSRCB, 2); ex("sw EXE", F_SEXT, 1);
        checkOutput(); step();
        ex("sw MEM", F_STATE, 3); ex("sw MEM", F_WMEM, 1); ex("sw MEM", F_IORD, 1);
        checkOutput(); step();
        ex("sw done", F_STATE, 0); checkOutput();
        step(); step(); step();
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b0);
        ex("sw2 MEM", F_STATE, 3); ex("sw2 MEM", F_WMEM, 1);
        checkOutput();
        do_reset();
        ex("sw2 rst", F_STATE, 0); ex("sw2 rst", F_WMEM, 0); ex("sw2 rst", F_IORD, 0);
        checkOutput();

        // beq and bne both with z = 1
        applyStimulus(6'b000100, 6'b000000, 1'b1, 1'b1);
        step(); step();
        ex("beq EXE", F_STATE, 2); ex("beq EXE", F_WPC, 1); ex("beq EXE", F_PCSRC, 1);
        ex("beq EXE", F_ALUC, 4); ex("beq EXE", F_SEXT, 1);
        checkOutput(); step();
        ex("beq next", F_STATE, 0); checkOutput();
        applyStimulus(6'b000101, 6'b000000, 1'b1, 1'b1);
        step(); step();
        ex("bne EXE", F_STATE, 2); ex("bne EXE", F_WPC, 0); ex("bne EXE", F_ALUC, 4);
        checkOutput(); step();
        ex("bne next", F_STATE, 0); checkOutput();

        // Jumps complete in ID
        applyStimulus(6'b000010, 6'b000000, 1'b0, 1'b1);
        step();
        ex("j ID", F_STATE, 1); ex("j ID", F_WPC, 1); ex("j ID", F_PCSRC, 3);
        ex("j ID", F_WREG, 0); ex("j ID", F_JAL, 0);
        checkOutput(); step();
        ex("j next", F_STATE, 0); checkOutput();
        applyStimulus(6'b000011, 6'b000000, 1'b0, 1'b1);
        step();
        ex("jal ID", F_WPC, 1); ex("jal ID", F_PCSRC, 3); ex("jal ID", F_WREG, 1);
        ex("jal ID", F_JAL, 1);
        checkOutput(); step();
        ex("jal next", F_STATE, 0); checkOutput();
        applyStimulus(6'b000000, 6'b001000, 1'b0, 1'b1);
        step();
        ex("jr ID", F_WPC, 1); ex("jr ID", F_PCSRC, 2); ex("jr ID", F_WREG, 0);
        checkOutput(); step();
        ex("jr next", F_STATE, 0); checkOutput();

        // Undecoded opcode: trap on d0, NOP on d1
        applyStimulus(6'b111111, 6'b000000, 1'b0, 1'b1);
        checkOutput(); step();
        exd("ill c2", 0, F_STATE, 1); exd("ill c2", 1, F_STATE, 1);
        checkOutput(); step();
        exd("ill c3", 0, F_STATE, 5); exd("ill c3", 0, F_ILL, 1);
        exd("ill c3", 0, F_WPC, 0); exd("ill c3", 0, F_WIR, 0);
        exd("ill c3", 0, F_WMEM, 0); exd("ill c3", 0, F_WREG, 0);
        exd("nop c3", 1, F_STATE, 0); exd("nop c3", 1, F_ILL, 0);
        checkOutput(); step();
        exd("ill hold", 0, F_STATE, 5); exd("ill hold", 0, F_ILL, 1);
        checkOutput();
        do_reset();
        exd("ill rst", 0, F_STATE, 0); exd("ill rst", 0, F_ILL, 0);
        checkOutput();

        // Fetch timeout on d2 (four wait cycles), d0 keeps waiting
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exd("to wait", 2, F_STATE, 0); exd("to wait", 2, F_WPC, 0);
            exd("to wait", 2, F_WIR, 0); exd("to wait", 2, F_MERR, 0);
            checkOutput(); step();
        end
        exd("to halt", 2, F_STATE, 5); exd("to halt", 2, F_MERR, 1);
        exd("to d0", 0, F_STATE, 0); exd("to d0", 0, F_MERR, 0);
        checkOutput(); step();
        exd("to hold", 2, F_STATE, 5); exd("to hold", 2, F_MERR, 1);
        exd("to hold", 2, F_WPC, 0);
        checkOutput();
        do_reset();
        exd("to rst", 2, F_STATE, 0); exd("to rst", 2, F_MERR, 0);
        exd("to rst", 2, F_ILL, 0);
        checkOutput();

        // mem_ready arriving in the limit cycle wins over the timeout
        for (int i = 0; i < 3; i++) step();
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
        exd("limit rdy", 2, F_STATE, 0); exd("limit rdy", 2, F_WPC, 1);
        exd("limit rdy", 2, F_WIR, 1);
        checkOutput(); step();
        exd("limit next", 2, F_STATE, 1); exd("limit next", 2, F_MERR, 0);
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
